// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops plus
// a shared shift/add datapath that iterates WIDTH cycles for MUL, DIV and REM.
module alu_multicycle #(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    c,
    output logic [WIDTH-1:0]    c_hi,
    output logic [3:0]          flags
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(8'h00);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(8'h01);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(8'h02);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(8'h03);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(8'h04);
    localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(8'h05);
    localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(8'h06);
    localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(8'h07);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8'h08);
    localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(8'h09);
    localparam logic [OP_WIDTH-1:0] OP_REM = OP_WIDTH'(8'h0A);
    localparam logic [OP_WIDTH-1:0] OP_ASR = OP_WIDTH'(8'h0B);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [OP_WIDTH-1:0] op_r;
    logic [WIDTH-1:0]    opnd_r;
    logic [WIDTH:0]      acc_hi_r;
    logic [WIDTH-1:0]    acc_lo_r;
    logic [WIDTH-1:0]    c_r, c_hi_r;
    logic [3:0]          flags_r;

    logic                accept_s, is_iter_s;
    logic [WIDTH:0]      add_s, sub_s;
    logic [WIDTH-1:0]    imm_c_s, imm_hi_s;
    logic                imm_v_s, imm_carry_s;
    logic [3:0]          imm_flags_s;
    logic [WIDTH:0]      mul_sum_s, div_shift_s, div_trial_s;
    logic                div_ge_s;
    logic [WIDTH:0]      iter_hi_s;
    logic [WIDTH-1:0]    iter_lo_s;
    logic [WIDTH-1:0]    fin_c_s, fin_hi_s;
    logic                fin_carry_s;
    logic [3:0]          fin_flags_s;

    function automatic logic [3:0] make_flags(input logic v, input logic carry,
                                              input logic [WIDTH-1:0] r);
        return {v, r[WIDTH-1], carry, (r == {WIDTH{1'b0}})};
    endfunction

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign c         = c_r;
    assign c_hi      = c_hi_r;
    assign flags     = flags_r;

    assign accept_s  = in_valid && (state_r == IDLE);
    assign is_iter_s = (op == OP_MUL) ||
                       (((op == OP_DIV) || (op == OP_REM)) && (b != {WIDTH{1'b0}}));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = is_iter_s ? BUSY : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Single-cycle results, including divide-by-zero and illegal opcodes
    always_comb begin
        add_s       = {1'b0, a} + {1'b0, b};
        sub_s       = {1'b0, a} - {1'b0, b};
        imm_c_s     = {WIDTH{1'b0}};
        imm_hi_s    = {WIDTH{1'b0}};
        imm_v_s     = 1'b0;
        imm_carry_s = 1'b0;
        case (op)
            OP_ADD: begin
                imm_c_s     = add_s[WIDTH-1:0];
                imm_carry_s = add_s[WIDTH];
                imm_v_s     = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_c_s     = sub_s[WIDTH-1:0];
                imm_carry_s = sub_s[WIDTH];
                imm_v_s     = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: imm_c_s = a & b;
            OP_OR:  imm_c_s = a | b;
            OP_XOR: imm_c_s = a ^ b;
            OP_NOT: imm_c_s = ~a;
            OP_SHL: begin
                imm_c_s     = {a[WIDTH-2:0], 1'b0};
                imm_carry_s = a[WIDTH-1];
            end
            OP_SHR: begin
                imm_c_s     = {1'b0, a[WIDTH-1:1]};
                imm_carry_s = a[0];
            end
            OP_ASR: begin
                imm_c_s     = {a[WIDTH-1], a[WIDTH-1:1]};
                imm_carry_s = a[0];
            end
            // Only reached with b==0; nonzero divisors take the iterative path
            OP_DIV: begin
                imm_c_s  = {WIDTH{1'b1}};
                imm_hi_s = a;
                imm_v_s  = 1'b1;
            end
            OP_REM: begin
                imm_c_s = a;
                imm_v_s = 1'b1;
            end
            default: imm_c_s = {WIDTH{1'b0}};
        endcase
        imm_flags_s = make_flags(imm_v_s, imm_carry_s, imm_c_s);
    end

    // One shift/add (MUL) or restoring-subtract (DIV/REM) step, plus final result
    always_comb begin
        mul_sum_s   = acc_hi_r + {1'b0, (acc_lo_r[0] ? opnd_r : {WIDTH{1'b0}})};
        div_shift_s = {acc_hi_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_r};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        fin_carry_s = 1'b0;
        if (op_r == OP_MUL) begin
            iter_hi_s   = {1'b0, mul_sum_s[WIDTH:1]};
            iter_lo_s   = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
            fin_c_s     = iter_lo_s;
            fin_hi_s    = iter_hi_s[WIDTH-1:0];
            fin_carry_s = (iter_hi_s[WIDTH-1:0] != {WIDTH{1'b0}});
        end else begin
            iter_hi_s = div_ge_s ? div_trial_s : div_shift_s;
            iter_lo_s = {acc_lo_r[WIDTH-2:0], div_ge_s};
            if (op_r == OP_REM) begin
                fin_c_s  = iter_hi_s[WIDTH-1:0];
                fin_hi_s = {WIDTH{1'b0}};
            end else begin
                fin_c_s  = iter_lo_s;
                fin_hi_s = iter_hi_s[WIDTH-1:0];
            end
        end
        fin_flags_s = make_flags(1'b0, fin_carry_s, fin_c_s);
    end

    // Operand capture, iteration registers and registered results
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= {OP_WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            acc_hi_r <= {(WIDTH+1){1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            c_r      <= {WIDTH{1'b0}};
            c_hi_r   <= {WIDTH{1'b0}};
            flags_r  <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && is_iter_s) begin
                        op_r     <= op;
                        opnd_r   <= (op == OP_MUL) ? a : b;
                        acc_lo_r <= (op == OP_MUL) ? b : a;
                        acc_hi_r <= {(WIDTH+1){1'b0}};
                        cnt_r    <= CNT_W'(WIDTH - 1);
                    end else if (accept_s) begin
                        c_r     <= imm_c_s;
                        c_hi_r  <= imm_hi_s;
                        flags_r <= imm_flags_s;
                    end else begin
                        c_r <= c_r;
                    end
                end
                BUSY: begin
                    acc_hi_r <= iter_hi_s;
                    acc_lo_r <= iter_lo_s;
                    cnt_r    <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        c_r     <= fin_c_s;
                        c_hi_r  <= fin_hi_s;
                        flags_r <= fin_flags_s;
                    end else begin
                        c_r <= c_r;
                    end
                end
                default: c_r <= c_r;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=8): directed vectors, reset abort,
// backpressure and randomized traffic checked against an arithmetic model.
module tb_alu_multicycle;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic [7:0] c_hi;
    logic [3:0] flags;

    alu_multicycle #(.WIDTH(8), .OP_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_hi      (c_hi),
        .flags     (flags)
    );

    typedef struct {
        logic [7:0] c;
        logic [7:0] hi;
        logic [3:0] f;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hold_cnt = 0;
    bit   bp_mode = 1'b0;
    bit   seen = 1'b0;
    bit   handed = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ux, uy, sx, sy, r;
        bit v, cy;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        e.hi = 8'h00; e.lat = 1; e.acc = 0; v = 1'b0; cy = 1'b0; r = 0;
        case (o)
            8'h00: begin r = ux + uy; cy = (r > 255); v = (sx + sy > 127) || (sx + sy < -128); end
            8'h01: begin r = ux - uy; cy = (ux < uy); v = (sx - sy > 127) || (sx - sy < -128); end
            8'h02: r = ux & uy;
            8'h03: r = ux | uy;
            8'h04: r = ux ^ uy;
            8'h05: r = 255 - ux;
            8'h06: begin r = ux * 2; cy = (ux >= 128); end
            8'h07: begin r = ux / 2; cy = ((ux % 2) == 1); end
            8'h08: begin r = ux * uy; e.hi = 8'(r / 256); cy = (e.hi != 8'h00); e.lat = 9; end
            8'h09: begin
                if (uy == 0) begin r = 255; e.hi = x; v = 1'b1; end
                else begin r = ux / uy; e.hi = 8'(ux % uy); e.lat = 9; end
            end
            8'h0A: begin
                if (uy == 0) begin r = ux; v = 1'b1; end
                else begin r = ux % uy; e.lat = 9; end
            end
            8'h0B: begin r = sx >>> 1; cy = ((ux % 2) == 1); end
            default: r = 0;
        endcase
        r = r & 255;
        e.c = 8'(r);
        e.f = {v, (e.c >= 8'h80), cy, (e.c == 8'h00)};
        return e;
    endfunction

    task automatic issue(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int waited;
        waited = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check(1'b0, "issue_timeout", 0, 1);
        end else begin
            e = model(o, x, y);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check(q.size() == 0, "drain_timeout", q.size(), 0);
    endtask

    // Monitor: latency, result and handshake checks, plus consumer backpressure
    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (handed) begin
                check(in_ready == 1'b1, "ready_after_handoff", in_ready, 1);
                handed = 1'b0;
            end
            if (q.size() > 0 && cyc >= q[0].acc && !out_valid)
                check(in_ready == 1'b0, "busy_in_ready", in_ready, 0);
            if (out_valid) begin
                check(in_ready == 1'b0, "done_in_ready", in_ready, 0);
                if (q.size() == 0) begin
                    check(1'b0, "spurious_valid", 1, 0);
                    out_ready = 1'b1;
                end else begin
                    e = q[0];
                    if (!seen) begin
                        check(cyc - e.acc + 1 == e.lat, "latency", cyc - e.acc + 1, e.lat);
                        seen = 1'b1;
                    end
                    check(c == e.c, "c", c, e.c);
                    check(c_hi == e.hi, "c_hi", c_hi, e.hi);
                    check(flags == e.f, "flags", flags, e.f);
                    if (hold_cnt > 0) begin
                        out_ready = 1'b0;
                        hold_cnt--;
                    end else if (bp_mode) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                        handed = 1'b1;
                    end
                end
            end else begin
                out_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] ro, ra, rb;
        reset = 1'b1; in_valid = 1'b0; op = 8'h00; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        check({c, c_hi, flags} == 20'h0, "reset_outputs", {c, c_hi, flags}, 0);

        issue(8'h00, 8'hFF, 8'h01);
        issue(8'h00, 8'h7F, 8'h01);
        issue(8'h08, 8'hFF, 8'hFF);
        issue(8'h09, 8'd200, 8'd7);
        issue(8'h09, 8'd5, 8'd0);
        issue(8'h0A, 8'd200, 8'd7);
        issue(8'h0A, 8'h9C, 8'd0);
        wait_drain();
        hold_cnt = 5;
        issue(8'h01, 8'd3, 8'd5);
        issue(8'h3C, 8'h12, 8'h34);
        issue(8'h07, 8'h01, 8'h00);
        issue(8'h0B, 8'h81, 8'h00);
        issue(8'h06, 8'h80, 8'h00);
        issue(8'h05, 8'hFF, 8'h00);
        wait_drain();

        // Reset four cycles into a multiply aborts it without a result
        issue(8'h08, 8'hAB, 8'hCD);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        check(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
        check({c, c_hi, flags} == 20'h0, "abort_outputs", {c, c_hi, flags}, 0);
        check(in_ready == 1'b1, "abort_in_ready", in_ready, 1);
        issue(8'h00, 8'd2, 8'd3);
        wait_drain();

        bp_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ro = 8'($urandom_range(0, 12));
            if (ro == 8'd12) ro = 8'($urandom_range(12, 255));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(ro, ra, rb);
        end
        wait_drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
